ca_atractor_det: RTL and testbench

Downstream observer for the cellular-automaton network. It samples the network's `Salida` state vector once per `clk` step while `sync` is high. It detects when the trajectory first revisits a state, and reports:
- the transient length (steps before the attractor is entered),
- the cycle period,
- the entry state of the cycle.

Results are held under a done/ack handshake so a host or logger can read one attractor measurement per run.

---
 rtl/ca_atractor_det.sv | 160 ++++++++++++++++
 tb/tb_ca_atractor_det.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/ca_atractor_det.sv
// ca_atractor_det -- attractor detector for the cellular-automaton network.
//
// Samples the network state once per clk step while sync is high. It records
// the step index at which each state is first seen. On the first revisit it
// latches:
//   - transitorio: the transient length,
//   - periodo:     the cycle period,
//   - entrada:     the cycle entry state.
// The result is then held under a done/ack handshake.
//
// Optional build macro: CA_ATRACTOR_REARM_EN
//   Defined:     HECHO+ack returns straight to IDLE, so traces run back-to-back.
//   Not defined: HECHO+ack parks in ESPERA until sync drops.
//
// Ports:
//   clk          system clock (same clock that steps the network)
//   reset        synchronous active-low reset
//   sync         network running; each edge with sync=1 is one step
//   estado[N]    network state sampled at the step edge
//   ack          host acknowledge of a held result
//   busy         trajectory being traced
//   done         result valid, held until ack
//   transitorio  first-visit index of the cycle-entry state
//   periodo      cycle length (1..2^N)
//   entrada      cycle-entry state
module ca_atractor_det #(
  parameter int unsigned N = 5
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           sync,
  input  logic [N-1:0]   estado,
  input  logic           ack,
  output logic           busy,
  output logic           done,
  output logic [N-1:0]   transitorio,
  output logic [N:0]     periodo,
  output logic [N-1:0]   entrada
);

  localparam int unsigned DEPTH = 2 ** N;
  localparam int unsigned PW    = N + 1;

`ifdef CA_ATRACTOR_REARM_EN
  typedef enum logic [1:0] {IDLE, TRAZA, HECHO} state_e;
`else
  typedef enum logic [1:0] {IDLE, TRAZA, HECHO, ESPERA} state_e;
`endif

  state_e             state_q, state_d;
  logic [PW-1:0]      paso_q, paso_d;
  logic [DEPTH-1:0]   visited_q, visited_d;
  logic [N-1:0]       idx_q [DEPTH];
  logic [N-1:0]       idx_d [DEPTH];
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [N-1:0]       transitorio_q, transitorio_d;
  logic [PW-1:0]      periodo_q, periodo_d;
  logic [N-1:0]       entrada_q, entrada_d;
  logic               hit_c;

  assign hit_c = visited_q[estado];

  // Next-state, table update and result latch.
  always_comb begin
    state_d       = state_q;
    paso_d        = paso_q;
    visited_d     = visited_q;
    idx_d         = idx_q;
    transitorio_d = transitorio_q;
    periodo_d     = periodo_q;
    entrada_d     = entrada_q;

    case (state_q)
      IDLE: begin
        if (sync) begin
          visited_d[estado] = 1'b1;
          idx_d[estado]     = '0;
          paso_d            = PW'(1);
          state_d           = TRAZA;
        end
      end
      TRAZA: begin
        if (!sync) begin
          state_d = IDLE;
        end else if (hit_c) begin
          transitorio_d = idx_q[estado];
          // paso is always greater than any recorded index, so this never underflows.
          periodo_d     = paso_q - PW'(idx_q[estado]);
          entrada_d     = estado;
          state_d       = HECHO;
        end else begin
          visited_d[estado] = 1'b1;
          idx_d[estado]     = N'(paso_q);
          paso_d            = paso_q + PW'(1);
        end
      end
      HECHO: begin
        if (ack) begin
`ifdef CA_ATRACTOR_REARM_EN
          state_d = IDLE;
`else
          state_d = ESPERA;
`endif
        end
      end
`ifndef CA_ATRACTOR_REARM_EN
      ESPERA: begin
        if (!sync) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase

    // The table is only live while tracing; clearing it on every other path
    // keeps IDLE with an empty table and no stale entries.
    if (state_d != TRAZA) begin
      visited_d = '0;
      paso_d    = '0;
    end

    busy_d = (state_d == TRAZA);
    done_d = (state_d == HECHO);
  end

  // Control, visited bits and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      paso_q        <= '0;
      visited_q     <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      transitorio_q <= '0;
      periodo_q     <= '0;
      entrada_q     <= '0;
    end else begin
      state_q       <= state_d;
      paso_q        <= paso_d;
      visited_q     <= visited_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      transitorio_q <= transitorio_d;
      periodo_q     <= periodo_d;
      entrada_q     <= entrada_d;
    end
  end

  // Index storage needs no reset: an entry is only read while its visited bit is set.
  always_ff @(posedge clk) begin
    idx_q <= idx_d;
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign transitorio = transitorio_q;
  assign periodo     = periodo_q;
  assign entrada     = entrada_q;

endmodule

// File: tb/tb_ca_atractor_det.sv
// Directed testbench for ca_atractor_det (N=5) with hand-computed expectations.
module tb_ca_atractor_det;

  logic       clk;
  logic       reset;
  logic       sync;
  logic [4:0] estado;
  logic       ack;
  logic       busy;
  logic       done;
  logic [4:0] transitorio;
  logic [5:0] periodo;
  logic [4:0] entrada;

  int n_checks = 0;
  int n_pass   = 0;

  ca_atractor_det #(.N(5)) dut (
    .clk         (clk),
    .reset       (reset),
    .sync        (sync),
    .estado      (estado),
    .ack         (ack),
    .busy        (busy),
    .done        (done),
    .transitorio (transitorio),
    .periodo     (periodo),
    .entrada     (entrada)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Apply inputs, take one clock edge, then settle before sampling.
  task automatic step(input logic s, input logic [4:0] e, input logic a);
    sync = s; estado = e; ack = a;
    @(posedge clk);
    #1;
  endtask

  task automatic check_result(input string tag, input logic [4:0] t,
                              input logic [5:0] p, input logic [4:0] e);
    check({tag, "_transitorio"}, 32'(transitorio), 32'(t));
    check({tag, "_periodo"},     32'(periodo),     32'(p));
    check({tag, "_entrada"},     32'(entrada),     32'(e));
  endtask

  initial begin
    reset = 1'b0; sync = 1'b0; estado = '0; ack = 1'b0;
    step(0, 0, 0);
    step(0, 0, 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check_result("rst", 5'h00, 6'd0, 5'h00);
    reset = 1'b1;
    step(0, 0, 0);

    // Fixed point 0x0A
    step(1, 5'h0A, 0);
    check("fp_busy1", 32'(busy), 1);
    check("fp_done1", 32'(done), 0);
    step(1, 5'h0A, 0);
    check("fp_done2", 32'(done), 1);
    check("fp_busy2", 32'(busy), 0);
    check_result("fp", 5'h00, 6'd1, 5'h0A);
    step(1, 5'h11, 0);                 // sync ignored in HECHO
    check("fp_hold_done", 32'(done), 1);
    check_result("fp_hold", 5'h00, 6'd1, 5'h0A);
    step(1, 5'h0A, 1);                 // ack with sync still high
    check("fp_ack_done", 32'(done), 0);
    check("fp_ack_busy", 32'(busy), 0);
    step(1, 5'h0A, 0);
`ifdef CA_ATRACTOR_REARM_EN
    check("rearm_busy", 32'(busy), 1);
`else
    check("rearm_busy", 32'(busy), 0);
    step(1, 5'h0A, 0);
    check("rearm_busy2", 32'(busy), 0);
`endif
    check_result("fp_kept", 5'h00, 6'd1, 5'h0A);
    step(0, 0, 0);                     // back to IDLE in both builds
    check("idle_busy", 32'(busy), 0);

    // Transient + 2-cycle: 03 07 01 07
    step(1, 5'h03, 0);
    step(1, 5'h07, 1);                 // ack outside HECHO is ignored
    step(1, 5'h01, 0);
    check("t2_busy_pre", 32'(busy), 1);
    check("t2_done_pre", 32'(done), 0);
    step(1, 5'h07, 0);
    check("t2_done", 32'(done), 1);
    check("t2_busy", 32'(busy), 0);
    check_result("t2", 5'h01, 6'd2, 5'h07);
    step(0, 0, 1);                     // ack wins over sync=0
    check("t2_ack_done", 32'(done), 0);
    step(0, 0, 0);

    // Maximal cycle 0..31 then 0
    for (int i = 0; i < 32; i++) step(1, 5'(i), 0);
    check("max_busy_pre", 32'(busy), 1);
    check("max_done_pre", 32'(done), 0);
    step(1, 5'h00, 0);
    check("max_done", 32'(done), 1);
    check_result("max", 5'h00, 6'b100000, 5'h00);
    step(0, 0, 1);
    step(0, 0, 0);

    // Abort after 4 distinct states, then fixed point 0x1F
    step(1, 5'h01, 0);
    step(1, 5'h02, 0);
    step(1, 5'h03, 0);
    step(1, 5'h04, 0);
    check("ab_busy", 32'(busy), 1);
    step(0, 0, 0);
    check("ab_done", 32'(done), 0);
    check("ab_busy_off", 32'(busy), 0);
    check("ab_kept_periodo", 32'(periodo), 32);
    step(1, 5'h1F, 0);
    step(1, 5'h1F, 0);
    check("ab_new_done", 32'(done), 1);
    check_result("ab_new", 5'h00, 6'd1, 5'h1F);

    // Reset while holding an unacknowledged result
    reset = 1'b0;
    step(1, 5'h1F, 0);
    reset = 1'b1;
    check("mr_busy", 32'(busy), 0);
    check("mr_done", 32'(done), 0);
    check_result("mr", 5'h00, 6'd0, 5'h00);
    step(0, 0, 0);
    // 0x1F was recorded before reset; a stale entry would cause a false hit.
    step(1, 5'h05, 0);
    step(1, 5'h1F, 0);
    check("mr_run_done_pre", 32'(done), 0);
    step(1, 5'h05, 0);
    check("mr_run_done", 32'(done), 1);
    check_result("mr_run", 5'h00, 6'd2, 5'h05);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
